// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues word requests to instruction
// memory and queues the returned words in order for decode. Redirects flush all fetch state.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned DW = 8;
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   fifo_pc_q [DEPTH];
    logic [31:0]   fifo_pc_d [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];

    logic pop;
    logic push;
    logic grant;
    logic credit_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign if_valid  = !rst && (count_q != '0);
    assign if_instr  = if_valid ? fifo_instr_q[head_q] : '0;
    assign if_pc     = if_valid ? fifo_pc_q[head_q] : '0;
    assign imem_addr = fetch_pc_q;

    // Credits count both in-flight kept requests and buffered words, so a kept
    // response always has a free slot; the pop term keeps 1 instr/cycle flowing.
    assign pop       = if_valid && if_ready;
    assign credit_ok = (SW'(outst_q) + SW'(count_q) - SW'(pop)) < SW'(DEPTH);
    assign imem_req  = !rst && !redirect_valid && credit_ok;
    assign grant     = imem_req && imem_gnt;
    assign push      = imem_rvalid && (drop_q == '0) && !redirect_valid;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        outst_d      = outst_q;
        count_d      = count_q;
        drop_d       = drop_q;
        head_d       = head_q;
        tail_d       = tail_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;

        if (redirect_valid) begin
            // Everything still in flight becomes stale, minus any word returning now.
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            resp_pc_d  = redirect_pc & 32'hFFFF_FFFC;
            drop_d     = drop_q + DW'(outst_q) - DW'(imem_rvalid);
            outst_d    = '0;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - DW'(1);
            end
            outst_d = outst_q + CW'(grant) - CW'(push);
            if (push) begin
                fifo_pc_d[tail_q]    = resp_pc_q;
                fifo_instr_d[tail_q] = imem_rdata;
                tail_d               = ptr_inc(tail_q);
                resp_pc_d            = resp_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC_ALIGNED;
            resp_pc_q  <= RESET_PC_ALIGNED;
            outst_q    <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            outst_q      <= outst_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a latency-programmable memory model feeds
// responses, and kept words are queued as expected decode outputs.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    int unsigned stale_cnt;
    logic [31:0] exp_fetch;
    logic [31:0] first_exp;
    bit          first_armed;
    int unsigned cyc;
    int          checks;
    int          failures;

    bit          t_rst;
    bit          t_redir;
    logic [31:0] t_rpc;
    bit          t_ready;
    bit          t_gnt;
    int unsigned lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs at negedge, sample #1 later, advance the model.
    task automatic cycle();
        bit          resp_now;
        bit          do_pop;
        bit          exp_req;
        int          npend;
        pend_t       p;
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        rst            = t_rst;
        redirect_valid = t_redir;
        redirect_pc    = t_rpc;
        if_ready       = t_ready;
        imem_gnt       = t_gnt;
        resp_now       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if (!t_rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            resp_now    = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = pend_q[0].addr >> 2;
        end
        #1;
        if (!if_valid) begin
            check("idle_pc", if_pc, 32'h0);
            check("idle_instr", if_instr, 32'h0);
        end
        if (t_rst) begin
            check("rst_req", 32'(imem_req), 32'h0);
            check("rst_valid", 32'(if_valid), 32'h0);
            pend_q.delete();
            exp_q.delete();
            stale_cnt   = 0;
            exp_fetch   = RESET_PC;
            first_exp   = RESET_PC;
            first_armed = 1'b1;
            return;
        end
        npend   = pend_q.size() - int'(stale_cnt);
        do_pop  = if_valid && if_ready && !t_redir;
        exp_req = !t_redir &&
                  ((npend + exp_q.size() - int'(if_valid && if_ready)) < int'(DEPTH));
        check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req) check("imem_addr", imem_addr, exp_fetch);
        if (if_valid && exp_q.size() > 0) begin
            check("if_pc", if_pc, exp_q[0]);
            check("if_instr", if_instr, exp_q[0] >> 2);
        end
        if (do_pop && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (first_armed) begin
                check("first_pc", e, first_exp);
                first_armed = 1'b0;
            end
        end
        if (resp_now) begin
            p = pend_q.pop_front();
            if (stale_cnt > 0) begin
                stale_cnt--;
            end else if (!t_redir) begin
                exp_q.push_back(p.addr);
                check("no_overflow", 32'(exp_q.size() <= DEPTH), 32'h1);
            end
        end
        if (imem_req && t_gnt) begin
            p.addr = exp_fetch;
            p.due  = cyc + lat;
            pend_q.push_back(p);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (t_redir) begin
            exp_q.delete();
            stale_cnt   = pend_q.size();
            exp_fetch   = t_rpc & 32'hFFFF_FFFC;
            first_exp   = t_rpc & 32'hFFFF_FFFC;
            first_armed = 1'b1;
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        t_redir = 1'b1;
        t_rpc   = pc;
        cycle();
        t_redir = 1'b0;
    endtask

    initial begin
        bit done;
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        checks = 0; failures = 0; cyc = 0; stale_cnt = 0;
        exp_fetch = RESET_PC; first_exp = RESET_PC; first_armed = 1'b0;
        t_rst = 1'b1; t_redir = 1'b0; t_rpc = '0; t_ready = 1'b1; t_gnt = 1'b1; lat = 1;

        // Reset fetch, steady 1-cycle memory
        repeat (2) cycle();
        t_rst = 1'b0;
        repeat (8) cycle();
        // Backpressure
        t_ready = 1'b0; repeat (5) cycle();
        t_ready = 1'b1; repeat (6) cycle();
        // Grant stall
        t_gnt = 1'b0; repeat (3) cycle();
        t_gnt = 1'b1; repeat (6) cycle();
        // Redirect with requests in flight on slow memory
        lat = 3; repeat (4) cycle();
        redirect(32'h0000_0103);
        repeat (10) cycle();
        // Redirect coincident with a response and a pop
        lat = 1; repeat (5) cycle();
        redirect(32'h0000_0040);
        repeat (6) cycle();
        // Back-to-back redirects
        lat = 3; repeat (3) cycle();
        redirect(32'h0000_0200);
        redirect(32'h0000_0302);
        repeat (10) cycle();
        // Mid-run reset with requests outstanding
        repeat (3) cycle();
        t_rst = 1'b1; cycle();
        t_rst = 1'b0; repeat (8) cycle();
        // Randomised handshakes, latency and redirects
        for (int i = 0; i < 120; i++) begin
            t_ready = 1'($urandom_range(0, 1));
            t_gnt   = 1'($urandom_range(0, 1));
            lat     = $urandom_range(1, 4);
            if ($urandom_range(0, 11) == 0) redirect($urandom);
            else cycle();
        end
        // Drain: stop granting and let everything retire
        t_gnt = 1'b0; t_ready = 1'b1; lat = 1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            done = (pend_q.size() == 0) && (exp_q.size() == 0);
        end
        check("drain_done", 32'(done), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
